// File: rtl/master_i2c.sv
// Single-byte I2C master: START, 7-bit address + R/W, one data byte, ACK/NACK, STOP.
// Open-drain SCL/SDA; every bit slot is four quarters of CLK_DIV clocks each.
module master_i2c #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] dev_addr,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output wire        scl,
   inout  wire        sda
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_ADDR  = 3'd2,
      ST_ACK1  = 3'd3,
      ST_DATA  = 3'd4,
      ST_ACK2  = 3'd5,
      ST_STOP  = 3'd6
   } state_t;

   localparam logic [7:0] QTR_LAST = 8'(CLK_DIV - 1);

   state_t     state_r, state_s;
   logic [7:0] qcnt_r, qcnt_s;
   logic [1:0] quarter_r, quarter_s;
   logic [2:0] bit_r, bit_s;
   logic [7:0] shift_r, shift_s;
   logic [7:0] wdata_r, wdata_s;
   logic       rw_r, rw_s;
   logic       busy_r, busy_s;
   logic       done_r, done_s;
   logic       ack_err_r, ack_err_s;
   logic [7:0] rd_data_r, rd_data_s;
   logic       scl_low_r, sda_low_r;
   logic [1:0] drive_s;
   logic       sda_meta_r, sda_sync_r;
   logic       tick_s, slot_end_s;

   // Line drive for a given state/quarter as {scl_low, sda_low}; 1 pulls the line to 0.
   function automatic logic [1:0] line_drive(input state_t st, input logic [1:0] q,
                                             input logic bit_v, input logic rd_v);
      logic       early;
      logic [1:0] drv;
      early = (q < 2'd2);
      case (st)
         ST_START:         drv = (q == 2'd3) ? 2'b11 : ((q == 2'd2) ? 2'b01 : 2'b00);
         ST_ADDR:          drv = {early, ~bit_v};
         ST_DATA:          drv = {early, ~bit_v & ~rd_v};
         ST_ACK1, ST_ACK2: drv = {early, 1'b0};
         ST_STOP:          drv = early ? 2'b11 : ((q == 2'd2) ? 2'b01 : 2'b00);
         default:          drv = 2'b00;
      endcase
      return drv;
   endfunction

   assign tick_s     = busy_r && (qcnt_r == QTR_LAST);
   assign slot_end_s = tick_s && (quarter_r == 2'd3);

   // Next-state, datapath and line-drive computation.
   always_comb begin
      state_s   = state_r;
      qcnt_s    = qcnt_r;
      quarter_s = quarter_r;
      bit_s     = bit_r;
      shift_s   = shift_r;
      wdata_s   = wdata_r;
      rw_s      = rw_r;
      busy_s    = busy_r;
      done_s    = 1'b0;
      ack_err_s = ack_err_r;
      rd_data_s = rd_data_r;

      if (busy_r) begin
         if (tick_s) begin
            qcnt_s    = 8'd0;
            quarter_s = quarter_r + 2'd1;
         end else begin
            qcnt_s = qcnt_r + 8'd1;
         end
      end else begin
         qcnt_s    = 8'd0;
         quarter_s = 2'd0;
      end

      case (state_r)
         ST_IDLE: begin
            // done_r marks the cycle IDLE was re-entered; a start there is dropped
            if (start && !done_r) begin
               state_s   = ST_START;
               shift_s   = {dev_addr, rw};
               wdata_s   = wr_data;
               rw_s      = rw;
               ack_err_s = 1'b0;
               busy_s    = 1'b1;
               bit_s     = 3'd0;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (slot_end_s) begin
               state_s = ST_ADDR;
               bit_s   = 3'd0;
            end else begin
               state_s = ST_START;
            end
         end
         ST_ADDR: begin
            if (slot_end_s) begin
               shift_s = {shift_r[6:0], sda_sync_r};
               bit_s   = bit_r + 3'd1;
               state_s = (bit_r == 3'd7) ? ST_ACK1 : ST_ADDR;
            end else begin
               state_s = ST_ADDR;
            end
         end
         ST_ACK1: begin
            if (slot_end_s) begin
               if (sda_sync_r) begin
                  ack_err_s = 1'b1;
                  state_s   = ST_STOP;
               end else begin
                  state_s = ST_DATA;
                  bit_s   = 3'd0;
                  shift_s = rw_r ? 8'h00 : wdata_r;
               end
            end else begin
               state_s = ST_ACK1;
            end
         end
         ST_DATA: begin
            // reads and writes share the shifter; on a write the shifted-in bits are ignored
            if (slot_end_s) begin
               shift_s = {shift_r[6:0], sda_sync_r};
               bit_s   = bit_r + 3'd1;
               if (bit_r == 3'd7) begin
                  state_s   = ST_ACK2;
                  rd_data_s = rw_r ? {shift_r[6:0], sda_sync_r} : rd_data_r;
               end else begin
                  state_s = ST_DATA;
               end
            end else begin
               state_s = ST_DATA;
            end
         end
         ST_ACK2: begin
            if (slot_end_s) begin
               ack_err_s = ack_err_r | (~rw_r & sda_sync_r);
               state_s   = ST_STOP;
            end else begin
               state_s = ST_ACK2;
            end
         end
         ST_STOP: begin
            if (slot_end_s) begin
               state_s = ST_IDLE;
               done_s  = 1'b1;
               busy_s  = 1'b0;
            end else begin
               state_s = ST_STOP;
            end
         end
         default: begin
            state_s = ST_IDLE;
            busy_s  = 1'b0;
         end
      endcase

      drive_s = line_drive(state_s, quarter_s, shift_s[7], rw_s);
   end

   // Controller state, datapath and registered line drivers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= ST_IDLE;
         qcnt_r    <= 8'd0;
         quarter_r <= 2'd0;
         bit_r     <= 3'd0;
         shift_r   <= 8'h00;
         wdata_r   <= 8'h00;
         rw_r      <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         ack_err_r <= 1'b0;
         rd_data_r <= 8'h00;
         scl_low_r <= 1'b0;
         sda_low_r <= 1'b0;
      end else begin
         state_r   <= state_s;
         qcnt_r    <= qcnt_s;
         quarter_r <= quarter_s;
         bit_r     <= bit_s;
         shift_r   <= shift_s;
         wdata_r   <= wdata_s;
         rw_r      <= rw_s;
         busy_r    <= busy_s;
         done_r    <= done_s;
         ack_err_r <= ack_err_s;
         rd_data_r <= rd_data_s;
         scl_low_r <= drive_s[1];
         sda_low_r <= drive_s[0];
      end
   end

   // Two-flop synchronizer for the SDA read-back path.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sda_meta_r <= 1'b1;
         sda_sync_r <= 1'b1;
      end else begin
         sda_meta_r <= sda;
         sda_sync_r <= sda_meta_r;
      end
   end

   assign scl     = scl_low_r ? 1'b0 : 1'bz;
   assign sda     = sda_low_r ? 1'b0 : 1'bz;
   assign busy    = busy_r;
   assign done    = done_r;
   assign ack_err = ack_err_r;
   assign rd_data = rd_data_r;

endmodule

// Handshake invariants of master_i2c: done is a lone pulse outside busy,
// and busy only rises after an accepted start.
module master_i2c_chk (
   input logic clk,
   input logic rst,
   input logic start,
   input logic busy,
   input logic done
);

   a_done_not_busy: assert property (@(posedge clk) disable iff (!rst) done |-> !busy);
   a_done_pulse:    assert property (@(posedge clk) disable iff (!rst) done |=> !done);
   a_busy_rise:     assert property (@(posedge clk) disable iff (!rst) $rose(busy) |-> $past(start));

endmodule

// File: tb/tb_master_i2c.sv
// Scoreboard bench for master_i2c: directed transactions against a bus-level slave model.
module tb_master_i2c;

   localparam int unsigned CLK_DIV  = 4;
   localparam int          LAT_FULL = 321;
   localparam int          LAT_NACK = 177;

   typedef struct packed {
      logic [31:0] start_cyc;
      logic [31:0] lat;
      logic        ack_err;
      logic [7:0]  rd;
      logic [7:0]  addr_b;
      logic        ack1;
      logic        full;
      logic [7:0]  data_b;
      logic        ack2;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] dev_addr = 7'h00;
   logic [7:0] wr_data = 8'h00;
   logic [7:0] rd_data;
   logic       busy, done, ack_err;
   wire        scl_w, sda_w;

   pullup (scl_w);
   pullup (sda_w);

   logic sl_low = 1'b0;
   assign sda_w = sl_low ? 1'b0 : 1'bz;

   master_i2c #(.CLK_DIV(CLK_DIV)) u_dut (
      .clk(clk), .rst(rst), .start(start), .rw(rw), .dev_addr(dev_addr),
      .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .done(done),
      .ack_err(ack_err), .scl(scl_w), .sda(sda_w)
   );

   master_i2c_chk u_chk (.clk(clk), .rst(rst), .start(start), .busy(busy), .done(done));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- slave model and bus-rule checker ----------------
   localparam logic [6:0] SL_ADDR = 7'h50;
   logic [7:0] sl_rd_byte = 8'h00;
   logic       sl_nack_data = 1'b0;
   logic       sl_acked = 1'b0;
   logic       sl_rw = 1'b0;
   logic [6:0] sl_a;
   int         sl_n = 0;
   logic       bits [0:19];
   int         start_cnt = 0;
   int         viol = 0;
   logic       frame_open = 1'b0;
   logic       scl_p = 1'b1;
   logic       sda_p = 1'b1;

   always @(negedge clk) begin
      if (!rst) begin
         sl_low     = 1'b0;
         sl_n       = 0;
         frame_open = 1'b0;
      end else if (scl_p && scl_w && sda_p && !sda_w) begin
         if (frame_open) viol++;
         frame_open = 1'b1;
         start_cnt++;
         sl_n   = 0;
         sl_low = 1'b0;
      end else if (scl_p && scl_w && !sda_p && sda_w) begin
         if (!frame_open) viol++;
         frame_open = 1'b0;
      end else if (!scl_p && scl_w) begin
         if (sl_n < 20) bits[sl_n] = sda_w;
         sl_n++;
      end else if (scl_p && !scl_w) begin
         if (sl_n == 8) begin
            for (int i = 0; i < 7; i++) sl_a[6-i] = bits[i];
            sl_rw    = bits[7];
            sl_acked = (sl_a == SL_ADDR);
            sl_low   = sl_acked;
         end else if (sl_n == 9) begin
            sl_low = sl_acked && sl_rw && !sl_rd_byte[7];
         end else if (sl_n >= 10 && sl_n <= 16) begin
            sl_low = sl_acked && sl_rw && !sl_rd_byte[16-sl_n];
         end else if (sl_n == 17) begin
            sl_low = sl_acked && !sl_rw && !sl_nack_data;
         end else begin
            sl_low = 1'b0;
         end
      end
      scl_p = scl_w;
      sda_p = sda_w;
   end

   // ---------------- scoreboard ----------------
   exp_t        exp_q [$];
   string       nm_q [$];
   logic [31:0] act_q [$];
   logic [31:0] req_q [$];
   int          n_cmp = 0;
   int          n_err = 0;
   exp_t        mon_e;
   logic [7:0]  mon_ab, mon_db;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   task automatic post(input string nm, input logic [31:0] act, input logic [31:0] req);
      nm_q.push_back(nm);
      act_q.push_back(act);
      req_q.push_back(req);
   endtask

   // Monitor: drains posted observations and checks every done against the next expectation.
   always @(negedge clk) begin
      while (nm_q.size() > 0) check(nm_q.pop_front(), act_q.pop_front(), req_q.pop_front());
      if (done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            for (int i = 0; i < 8; i++) begin
               mon_ab[7-i] = bits[i];
               mon_db[7-i] = bits[9+i];
            end
            check("done_latency", 32'(cyc) - mon_e.start_cyc + 32'd1, mon_e.lat);
            check("ack_err", {31'd0, ack_err}, {31'd0, mon_e.ack_err});
            check("rd_data", {24'd0, rd_data}, {24'd0, mon_e.rd});
            check("busy_at_done", {31'd0, busy}, 32'd0);
            check("addr_byte", {24'd0, mon_ab}, {24'd0, mon_e.addr_b});
            check("ack1_bit", {31'd0, bits[8]}, {31'd0, mon_e.ack1});
            if (mon_e.full) begin
               check("data_byte", {24'd0, mon_db}, {24'd0, mon_e.data_b});
               check("ack2_bit", {31'd0, bits[17]}, {31'd0, mon_e.ack2});
            end
         end
      end
   end

   // ---------------- driver ----------------
   function automatic exp_t mk_exp(input int lat, input logic ae, input logic [7:0] rd,
                                   input logic [7:0] ab, input logic a1, input logic full,
                                   input logic [7:0] db, input logic a2);
      exp_t e;
      e.start_cyc = 32'd0;
      e.lat = 32'(lat);
      e.ack_err = ae;
      e.rd = rd;
      e.addr_b = ab;
      e.ack1 = a1;
      e.full = full;
      e.data_b = db;
      e.ack2 = a2;
      return e;
   endfunction

   task automatic pulse_start(input logic r, input logic [6:0] a, input logic [7:0] d);
      @(negedge clk);
      rw = r; dev_addr = a; wr_data = d; start = 1'b1;
      @(negedge clk);
      start = 1'b0; rw = ~r; dev_addr = ~a; wr_data = ~d;
   endtask

   task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d, input exp_t e_in);
      exp_t e;
      @(negedge clk);
      rw = r; dev_addr = a; wr_data = d; start = 1'b1;
      e = e_in;
      e.start_cyc = 32'(cyc + 1);
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0; rw = ~r; dev_addr = ~a; wr_data = ~d;
      post("busy_after_start", {31'd0, busy}, 32'd1);
   endtask

   task automatic wait_done(input int budget);
      int k;
      k = 0;
      while (!done && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (!done) post("done_timeout", 32'd0, 32'd1);
   endtask

   int s0;

   initial begin
      repeat (3) @(negedge clk);
      post("rst_busy", {31'd0, busy}, 32'd0);
      post("rst_done", {31'd0, done}, 32'd0);
      post("rst_ack_err", {31'd0, ack_err}, 32'd0);
      post("rst_rd_data", {24'd0, rd_data}, 32'h00);
      post("rst_scl", {31'd0, scl_w}, 32'd1);
      post("rst_sda", {31'd0, sda_w}, 32'd1);
      rst = 1'b1;
      repeat (3) @(negedge clk);

      // write 0x50 <- 0xA5, then a start coincident with done must be ignored
      issue(1'b0, 7'h50, 8'hA5, mk_exp(LAT_FULL, 1'b0, 8'h00, 8'hA0, 1'b0, 1'b1, 8'hA5, 1'b0));
      wait_done(1000);
      rw = 1'b0; dev_addr = 7'h50; wr_data = 8'h11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      post("start_at_done_ignored", {31'd0, busy}, 32'd0);
      repeat (10) @(negedge clk);

      // read 0x50, slave returns 0x3C, master NACKs
      sl_rd_byte = 8'h3C;
      issue(1'b1, 7'h50, 8'h00, mk_exp(LAT_FULL, 1'b0, 8'h3C, 8'hA1, 1'b0, 1'b1, 8'h3C, 1'b1));
      wait_done(1000);
      repeat (5) @(negedge clk);

      // address 0x11 with nobody home: short frame, ack_err held afterwards
      issue(1'b0, 7'h11, 8'h77, mk_exp(LAT_NACK, 1'b1, 8'h3C, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0));
      wait_done(1000);
      repeat (5) @(negedge clk);
      post("ack_err_held", {31'd0, ack_err}, 32'd1);

      // data byte NACKed by slave: full frame, ack_err set
      sl_nack_data = 1'b1;
      issue(1'b0, 7'h50, 8'h5A, mk_exp(LAT_FULL, 1'b1, 8'h3C, 8'hA0, 1'b0, 1'b1, 8'h5A, 1'b1));
      wait_done(1000);
      sl_nack_data = 1'b0;
      repeat (5) @(negedge clk);

      // start pulsed during ADDR is ignored
      s0 = start_cnt;
      issue(1'b0, 7'h50, 8'h0F, mk_exp(LAT_FULL, 1'b0, 8'h3C, 8'hA0, 1'b0, 1'b1, 8'h0F, 1'b0));
      repeat (40) @(negedge clk);
      pulse_start(1'b1, 7'h11, 8'hFF);
      wait_done(1000);
      post("single_start_condition", 32'(start_cnt - s0), 32'd1);
      repeat (5) @(negedge clk);

      // second read pattern
      sl_rd_byte = 8'hC3;
      issue(1'b1, 7'h50, 8'h00, mk_exp(LAT_FULL, 1'b0, 8'hC3, 8'hA1, 1'b0, 1'b1, 8'hC3, 1'b1));
      wait_done(1000);
      repeat (5) @(negedge clk);

      // reset during DATA: lines released at once, no done afterwards
      pulse_start(1'b0, 7'h50, 8'h00);
      repeat (200) @(negedge clk);
      rst = 1'b0;
      #1;
      post("mid_rst_scl", {31'd0, scl_w}, 32'd1);
      post("mid_rst_sda", {31'd0, sda_w}, 32'd1);
      post("mid_rst_busy", {31'd0, busy}, 32'd0);
      post("mid_rst_rd_data", {24'd0, rd_data}, 32'h00);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (400) @(negedge clk);
      post("post_rst_busy", {31'd0, busy}, 32'd0);
      post("bus_rule_violations", 32'(viol), 32'd0);
      post("pending_expectations", 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
